// File: rtl/pipe_stage_buf.sv
// Reusable pipeline-stage register with valid/ready handshake and flush.
// Define PIPE_STAGE_SKID_EN to add a second (skid) entry with a registered in_ready.
module pipe_stage_buf #(
    parameter int DATA_W = 101,
    parameter int CTRL_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic [CTRL_W-1:0] m_ctrl;
    logic              acc;
    logic              pop;

    assign acc       = in_valid && in_ready;
    assign pop       = m_valid && out_ready;
    assign out_valid = m_valid;
    assign out_data  = m_data;
    // A bubble must never carry write enables downstream.
    assign out_ctrl  = m_valid ? m_ctrl : '0;

`ifdef PIPE_STAGE_SKID_EN
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic [CTRL_W-1:0] s_ctrl;

    assign in_ready  = !s_valid;
    assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_ctrl  <= '0;
            s_valid <= 1'b0;
            s_data  <= '0;
            s_ctrl  <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
            m_ctrl  <= '0;
            s_valid <= 1'b0;
            s_ctrl  <= '0;
        end else if (!m_valid || pop) begin
            // S holds the younger entry, so it refills M before any new input.
            s_valid <= 1'b0;
            if (s_valid) begin
                m_valid <= 1'b1;
                m_data  <= s_data;
                m_ctrl  <= s_ctrl;
            end else if (acc) begin
                m_valid <= 1'b1;
                m_data  <= in_data;
                m_ctrl  <= in_ctrl;
            end else begin
                m_valid <= 1'b0;
            end
        end else if (acc) begin
            s_valid <= 1'b1;
            s_data  <= in_data;
            s_ctrl  <= in_ctrl;
        end
    end
`else
    assign in_ready  = !m_valid || out_ready;
    assign occupancy = {1'b0, m_valid};

    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_ctrl  <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
            m_ctrl  <= '0;
        end else if (acc) begin
            m_valid <= 1'b1;
            m_data  <= in_data;
            m_ctrl  <= in_ctrl;
        end else if (pop) begin
            m_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf; covers reset, streaming, stall,
// flush, bubble masking and the build-specific back-pressure behaviour.
module tb_pipe_stage_buf;

    localparam int DW = 101;
    localparam int CW = 2;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [1:0]    occupancy;

    ent_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW)) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_ctrl(in_ctrl),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_ctrl(out_ctrl),
        .occupancy(occupancy)
    );

    function automatic logic [DW-1:0] rnd();
        logic [127:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    // Drive one cycle's inputs away from the edge and report handshakes.
    task automatic cyc(input bit v, input logic [DW-1:0] d,
                       input logic [CW-1:0] c, input bit r, input bit f,
                       input bit rst, output bit acc, output bit pop);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = r;
        flush     = f;
        reset     = rst;
        #1;
        acc = in_valid && in_ready;
        pop = out_valid && out_ready;
    endtask

    task automatic test_reset();
        bit a, p;
        cyc(1, rnd(), 2'b11, 1, 0, 1, a, p);
        cyc(1, rnd(), 2'b11, 1, 1, 1, a, p);
        cyc(0, '0, '0, 0, 0, 0, a, p);
        sb.delete();
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_valid got=%b want=0", out_valid);
        end
        total++;
        if (out_ctrl !== 2'b00) begin
            bad++; $display("FAIL reset_ctrl got=%b want=00", out_ctrl);
        end
        total++;
        if (out_data !== '0) begin
            bad++; $display("FAIL reset_data got=%h want=0", out_data);
        end
        total++;
        if (occupancy !== 2'd0) begin
            bad++; $display("FAIL reset_occ got=%0d want=0", occupancy);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
    endtask

    task automatic test_stream();
        bit a, p;
        int pops = 0;
        for (int i = 0; i < 9; i++) begin
            ent_t e;
            e.d = rnd();
            e.c = 2'b11;
            cyc(i < 8, e.d, e.c, 1, 0, 0, a, p);
            if (i < 8) begin
                total++;
                if (in_ready !== 1'b1) begin
                    bad++; $display("FAIL stream_ready i=%0d got=%b want=1", i, in_ready);
                end
            end
            if (i >= 1) begin
                total++;
                if (out_valid !== 1'b1 || occupancy !== 2'd1) begin
                    bad++;
                    $display("FAIL stream_gap i=%0d valid=%b occ=%0d want 1/1",
                             i, out_valid, occupancy);
                end
            end
            if (p) begin
                pops++;
                total++;
                if (sb.size() == 0 || out_data !== sb[0].d || out_ctrl !== sb[0].c) begin
                    bad++; $display("FAIL stream_order got=%h/%b", out_data, out_ctrl);
                end
                if (sb.size() != 0) void'(sb.pop_front());
            end
            if (a) sb.push_back(e);
        end
        total++;
        if (pops != 8) begin
            bad++; $display("FAIL stream_count got=%0d want=8", pops);
        end
    endtask

`ifdef PIPE_STAGE_SKID_EN
    task automatic test_backpressure();
        bit a, p;
        ent_t e[3];
        int idx = 0;
        int pops = 0;
        for (int i = 0; i < 3; i++) begin
            e[i].d = rnd();
            e[i].c = CW'(i + 1);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1, e[idx].d, e[idx].c, 0, 0, 0, a, p);
            if (i == 2) begin
                total++;
                if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL bp_full occ=%0d ready=%b want 2/0", occupancy, in_ready);
                end
            end
            if (i >= 2) begin
                total++;
                if (a) begin
                    bad++; $display("FAIL bp_hold acc=1 want=0");
                end
            end
            if (a) begin
                sb.push_back(e[idx]);
                idx++;
            end
        end
        for (int i = 0; i < 10; i++) begin
            cyc(idx < 3, e[idx < 3 ? idx : 2].d, e[idx < 3 ? idx : 2].c,
                1, 0, 0, a, p);
            if (p) begin
                pops++;
                total++;
                if (sb.size() == 0 || out_data !== sb[0].d || out_ctrl !== sb[0].c) begin
                    bad++; $display("FAIL bp_order got=%h/%b", out_data, out_ctrl);
                end
                if (sb.size() != 0) void'(sb.pop_front());
            end
            if (a) begin
                sb.push_back(e[idx]);
                idx++;
            end
        end
        total++;
        if (pops != 3 || idx != 3) begin
            bad++; $display("FAIL bp_drain pops=%0d acc=%0d want 3/3", pops, idx);
        end
    endtask
`else
    task automatic test_noskid();
        bit a, p;
        ent_t ea, eb;
        ea.d = rnd(); ea.c = 2'b10;
        eb.d = rnd(); eb.c = 2'b01;
        cyc(1, ea.d, ea.c, 0, 0, 0, a, p);
        if (a) sb.push_back(ea);
        cyc(1, eb.d, eb.c, 0, 0, 0, a, p);
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL ns_stall_ready got=%b want=0", in_ready);
        end
        out_ready = 1'b1;
        #1;
        a = in_valid && in_ready;
        p = out_valid && out_ready;
        total++;
        if (in_ready !== 1'b1 || !a || !p) begin
            bad++;
            $display("FAIL ns_comb_ready ready=%b acc=%b pop=%b want 1/1/1", in_ready, a, p);
        end
        if (p) begin
            total++;
            if (sb.size() == 0 || out_data !== sb[0].d || out_ctrl !== sb[0].c) begin
                bad++; $display("FAIL ns_pop got=%h/%b", out_data, out_ctrl);
            end
            if (sb.size() != 0) void'(sb.pop_front());
        end
        if (a) sb.push_back(eb);
        cyc(0, '0, '0, 0, 0, 0, a, p);
        total++;
        if (occupancy !== 2'd1 || out_data !== eb.d || out_ctrl !== eb.c) begin
            bad++;
            $display("FAIL ns_replace occ=%0d data=%h ctrl=%b", occupancy, out_data, out_ctrl);
        end
        cyc(0, '0, '0, 1, 0, 0, a, p);
        if (p) begin
            total++;
            if (sb.size() == 0 || out_data !== sb[0].d || out_ctrl !== sb[0].c) begin
                bad++; $display("FAIL ns_drain got=%h/%b", out_data, out_ctrl);
            end
            if (sb.size() != 0) void'(sb.pop_front());
        end
    endtask
`endif

    task automatic test_flush();
        bit a, p;
        logic [DW-1:0] kept;
        for (int i = 0; i < 4; i++) begin
            ent_t e;
            e.d = rnd();
            e.c = 2'b11;
            cyc(1, e.d, e.c, 0, 0, 0, a, p);
            if (a) sb.push_back(e);
            else break;
        end
        kept = sb.size() != 0 ? sb[0].d : '0;
        cyc(1, rnd(), 2'b11, 1, 1, 0, a, p);
        if (p) begin
            total++;
            if (sb.size() == 0 || out_data !== sb[0].d || out_ctrl !== sb[0].c) begin
                bad++; $display("FAIL flush_pop got=%h/%b", out_data, out_ctrl);
            end
        end
        sb.delete();
        cyc(1, rnd(), 2'b11, 0, 1, 0, a, p);
        total++;
        if (out_valid !== 1'b0 || out_ctrl !== 2'b00 || occupancy !== 2'd0) begin
            bad++;
            $display("FAIL flush_empty valid=%b ctrl=%b occ=%0d want 0/00/0",
                     out_valid, out_ctrl, occupancy);
        end
        total++;
        if (out_data !== kept) begin
            bad++; $display("FAIL flush_data_kept got=%h want=%h", out_data, kept);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(0, '0, '0, 1, 0, 0, a, p);
            total++;
            if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
                bad++; $display("FAIL flush_leak i=%0d valid=%b occ=%0d", i, out_valid, occupancy);
            end
        end
    endtask

    task automatic test_bubble();
        bit a, p;
        ent_t e;
        e.d = rnd();
        e.c = 2'b01;
        cyc(1, e.d, e.c, 1, 0, 0, a, p);
        if (a) sb.push_back(e);
        cyc(0, '0, '0, 1, 0, 0, a, p);
        total++;
        if (!p || sb.size() == 0 || out_data !== sb[0].d || out_ctrl !== sb[0].c) begin
            bad++; $display("FAIL bubble_pop pop=%b got=%h/%b", p, out_data, out_ctrl);
        end
        if (sb.size() != 0) void'(sb.pop_front());
        cyc(0, '0, '0, 1, 0, 0, a, p);
        total++;
        if (out_valid !== 1'b0 || out_ctrl !== 2'b00) begin
            bad++; $display("FAIL bubble_ctrl valid=%b ctrl=%b want 0/00", out_valid, out_ctrl);
        end
        total++;
        if (out_data !== e.d) begin
            bad++; $display("FAIL bubble_data got=%h want=%h", out_data, e.d);
        end
    endtask

    task automatic test_reset_mid();
        bit a, p;
        for (int i = 0; i < 2; i++) begin
            cyc(1, rnd(), 2'b11, 0, 0, 0, a, p);
        end
        cyc(1, rnd(), 2'b11, 1, 0, 1, a, p);
        sb.delete();
        for (int i = 0; i < 4; i++) begin
            cyc(0, '0, '0, 1, 0, 0, a, p);
            total++;
            if (out_valid !== 1'b0 || out_data !== '0 || occupancy !== 2'd0) begin
                bad++;
                $display("FAIL reset_mid i=%0d valid=%b data=%h occ=%0d",
                         i, out_valid, out_data, occupancy);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        out_ready = 1'b0;
        test_reset();
        test_stream();
`ifdef PIPE_STAGE_SKID_EN
        test_backpressure();
`else
        test_noskid();
`endif
        test_flush();
        test_bubble();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline-stage register with a valid/ready handshake, synchronous flush and an optional two-entry skid buffer. It generalises the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) into one reusable block. Payload width and control-field width are parameters. Bubbles force the control field to zero, so a squashed or empty slot can never write the register file or memory.

## Interface
Parameters:
- DATA_W, default 101: payload bits (instr, ALU result, read data, write register).
- CTRL_W, default 2: control bits (RegWrite, MemtoReg, ...). Forced to 0 whenever the slot is not valid.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset; synchronous, active-high.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  upstream has a transfer.
- in_ready  out  1  stage can accept a transfer this cycle.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control bits.
- out_valid  out  1  stage presents a valid entry.
- out_ready  in  1  downstream accepts the presented entry.
- out_data  out  DATA_W  presented payload.
- out_ctrl  out  CTRL_W  presented control bits; 0 when out_valid=0.
- occupancy  out  2  number of held entries (0..2).

## Operation
- Input transfer (acc): in_valid && in_ready. Output transfer (pop): out_valid && out_ready.
- Main slot M drives the outputs. Skid slot S exists only with the macro enabled.
- Priority per edge: reset > flush > normal update.
- reset: M and S are invalid; data and ctrl registers are 0.
- flush: M and S are invalid; ctrl registers are 0; data registers keep their contents. A same-cycle acc is dropped. A same-cycle pop completes downstream; the entry is still discarded.
- Normal update with skid:
  - If M is empty or pop: M loads S if S is valid, otherwise M loads the input if acc, otherwise M becomes empty. S is emptied.
  - If M is valid, no pop and acc: the input goes to S.
  - in_ready = !S_valid, driven from a register (no combinational path from out_ready).
- Normal update without skid (no S):
  - in_ready = !M_valid || out_ready (combinational).
  - M loads the input on acc; otherwise M empties on pop.
- Order is preserved: S always holds the younger entry.
- out_ctrl = M_valid ? M_ctrl : 0. out_data = M_data, which holds its last value when invalid.
- occupancy = M_valid + S_valid.
- Stall: out_ready=0 holds M. The upstream is back-pressured once full: after 2 entries with skid, after 1 without.

## Timing
- Values after reset: out_valid=0, out_data=0, out_ctrl=0, occupancy=0, in_ready=1.
- Latency: an acc at edge N appears on out_valid/out_data after edge N when M was empty or popping.
- Throughput: 1 transfer/cycle sustained while out_ready=1.
- With skid, in_ready drops the cycle after S fills. It rises the cycle after S drains.
- Simultaneous acc and pop in the full state (skid build): not possible, because in_ready=0.
- Simultaneous acc and pop with occupancy 1: M is replaced by the new entry; occupancy stays 1.
- flush during reset: reset wins. flush for multiple cycles: the stage stays empty.
- reset mid-transfer: all in-flight entries are lost; nothing appears on the output afterwards.

## Configuration
- PIPE_STAGE_SKID_EN defined: two-entry skid buffer; in_ready is registered; timing is decoupled between stages; occupancy reaches 2.
- Not defined: single register; in_ready depends combinationally on out_ready; occupancy[1] is tied to 0; smaller area.

## Test plan
- Reset then idle: after reset is held 2 cycles, out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1.
- Streaming: 8 back-to-back entries with in_ctrl=2'b11 and out_ready=1. Each entry appears 1 cycle after acceptance, in order, with no gaps.
- Back-pressure (skid): out_ready=0 and 3 consecutive valid inputs A, B, C. A and B are accepted and occupancy=2. in_ready=0 from the cycle after B. C is held upstream. out_ready=1 then drains A, B, C in order.
- Flush: occupancy=2, then flush=1 for 1 cycle with in_valid=1 (D). Next cycle: out_valid=0, out_ctrl=0, occupancy=0, and D is never output.
- Bubble control masking: entry with in_ctrl=2'b01 is popped, then no input. out_ctrl=0 while out_valid=0, even though out_data still holds the last payload.
- No-skid build: with out_ready=0 and M full, in_ready=0 in the same cycle. Raising out_ready=1 raises in_ready combinationally, and acc and pop complete on the same edge.
